// File: rtl/insn_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : insn_prefetch_queue
// Purpose  : Instruction fetch front end. Owns the PC, issues word reads to a
//            synchronous 1-cycle-latency instruction memory, buffers returned
//            {insn, pc} pairs in a small FIFO and presents the head entry to
//            the decoder over a valid/ready handshake. A redirect flushes all
//            buffered and in-flight fetches and restarts at the target PC.
// Ports    : clk            - clock, rising edge
//            rst            - synchronous reset, active low
//            imem_en        - memory read strobe
//            imem_addr      - memory word address (current PC)
//            imem_data      - memory read data, one cycle after imem_en
//            redirect_valid - flush and restart request
//            redirect_pc    - restart address
//            insn_valid     - head entry available
//            insn_ready     - decoder accepts head entry
//            insn_o         - head instruction (0 when empty)
//            insn_pc_o      - PC of head instruction (0 when empty)
// Revision : 1.0 - initial release
// ============================================================================
module insn_prefetch_queue #(
    parameter int                  LEN_INSN = 32,
    parameter int                  LEN_ADDR = 16,
    parameter int                  DEPTH    = 4,
    parameter logic [LEN_ADDR-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_en,
    output logic [LEN_ADDR-1:0] imem_addr,
    input  logic [LEN_INSN-1:0] imem_data,
    input  logic                redirect_valid,
    input  logic [LEN_ADDR-1:0] redirect_pc,
    output logic                insn_valid,
    input  logic                insn_ready,
    output logic [LEN_INSN-1:0] insn_o,
    output logic [LEN_ADDR-1:0] insn_pc_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    // One extra bit so count + inflight can never overflow the compare.
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    logic [LEN_ADDR-1:0] r_pc;
    logic [LEN_ADDR-1:0] r_inflight_pc;
    logic                r_inflight;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [LEN_INSN-1:0] r_fifo_insn [DEPTH];
    logic [LEN_ADDR-1:0] r_fifo_pc   [DEPTH];

    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_nonempty;
    logic [c_CNT_W:0]    w_occupancy;

    // Reserve a slot for every outstanding fetch so a returning word always
    // has room; this is what makes a push into a full FIFO impossible.
    assign w_occupancy = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_issue     = rst & ~redirect_valid & (w_occupancy < c_DEPTH);
    assign w_push      = r_inflight & ~redirect_valid;
    assign w_nonempty  = (r_count != '0);
    assign w_pop       = w_nonempty & insn_ready & ~redirect_valid;

    assign imem_en     = w_issue;
    assign imem_addr   = r_pc;
    assign insn_valid  = rst & w_nonempty;
    assign insn_o      = insn_valid ? r_fifo_insn[r_rd_ptr] : '0;
    assign insn_pc_o   = insn_valid ? r_fifo_pc[r_rd_ptr]   : '0;

    // Control state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Flush wins over push, pop and issue; returning data is dropped.
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= r_pc + 1'b1;
                r_inflight_pc <= r_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_fifo_insn[r_wr_ptr] <= imem_data;
            r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_insn_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_insn_prefetch_queue
// Purpose  : Directed self-checking bench for insn_prefetch_queue. A second
//            instance with RESET_PC=0xFFFE covers PC wrap-around. Memory
//            model returns 0x1000 + address one cycle after each read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_insn_prefetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn_o;
    logic [15:0] insn_pc_o;

    logic        imem_en_w;
    logic [15:0] imem_addr_w;
    logic [31:0] imem_data_w;
    logic        insn_valid_w;
    logic [31:0] insn_o_w;
    logic [15:0] insn_pc_o_w;

    int total = 0;
    int bad   = 0;

    insn_prefetch_queue #(
        .LEN_INSN(32), .LEN_ADDR(16), .DEPTH(4), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .insn_valid(insn_valid), .insn_ready(insn_ready),
        .insn_o(insn_o), .insn_pc_o(insn_pc_o)
    );

    insn_prefetch_queue #(
        .LEN_INSN(32), .LEN_ADDR(16), .DEPTH(4), .RESET_PC(16'hFFFE)
    ) dut_w (
        .clk(clk), .rst(rst),
        .imem_en(imem_en_w), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .insn_valid(insn_valid_w), .insn_ready(1'b1),
        .insn_o(insn_o_w), .insn_pc_o(insn_pc_o_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        imem_data   = 32'h0;
        imem_data_w = 32'h0;
    end

    always @(posedge clk) begin
        if (imem_en)   imem_data   <= 32'h1000 + {16'h0, imem_addr};
        if (imem_en_w) imem_data_w <= 32'h1000 + {16'h0, imem_addr_w};
    end

    // Holds reset for two edges and releases it at a falling edge.
    task automatic start(input logic ready);
        rst            = 1'b0;
        insn_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        insn_ready = ready;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; insn_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL reset_imem_en: got %0b want 0", imem_en); end
        total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", insn_valid); end
        total++; if (insn_o !== 32'h0) begin bad++; $display("FAIL reset_insn: got %0h want 0", insn_o); end
        total++; if (insn_pc_o !== 16'h0) begin bad++; $display("FAIL reset_pc: got %0h want 0", insn_pc_o); end
        total++; if (imem_en_w !== 1'b0) begin bad++; $display("FAIL reset_imem_en_w: got %0b want 0", imem_en_w); end
    endtask

    task automatic test_stream();
        start(1'b1);
        total++; if (imem_en !== 1'b1 || imem_addr !== 16'h0) begin bad++; $display("FAIL stream_first_issue: got en=%0b addr=%0h want en=1 addr=0", imem_en, imem_addr); end
        total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL stream_valid_n0: got %0b want 0", insn_valid); end
        @(negedge clk);
        total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL stream_valid_n1: got %0b want 0", insn_valid); end
        total++; if (imem_addr !== 16'h1) begin bad++; $display("FAIL stream_addr_n1: got %0h want 1", imem_addr); end
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            total++;
            if (insn_valid !== 1'b1 || insn_pc_o !== 16'(k) || insn_o !== 32'h1000 + 32'(k)) begin
                bad++;
                $display("FAIL stream_k%0d: got v=%0b pc=%0h insn=%0h want v=1 pc=%0h insn=%0h",
                         k, insn_valid, insn_pc_o, insn_o, k, 32'h1000 + 32'(k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int issues;
        int got;
        issues = 0;
        got    = 0;
        start(1'b0);
        for (int c = 0; c < 10; c++) begin
            if (imem_en) begin
                total++; if (imem_addr !== 16'(issues)) begin bad++; $display("FAIL bp_issue_addr: got %0h want %0h", imem_addr, issues); end
                issues++;
            end
            @(negedge clk);
        end
        total++; if (issues !== 4) begin bad++; $display("FAIL bp_issue_count: got %0d want 4", issues); end
        total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL bp_en_full: got %0b want 0", imem_en); end
        total++; if (insn_valid !== 1'b1 || insn_pc_o !== 16'h0) begin bad++; $display("FAIL bp_head: got v=%0b pc=%0h want v=1 pc=0", insn_valid, insn_pc_o); end
        insn_ready = 1'b1;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (insn_valid) begin
                total++;
                if (insn_pc_o !== 16'(got) || insn_o !== 32'h1000 + 32'(got)) begin
                    bad++;
                    $display("FAIL bp_drain: got pc=%0h insn=%0h want pc=%0h insn=%0h", insn_pc_o, insn_o, got, 32'h1000 + 32'(got));
                end
                got++;
            end
            @(negedge clk);
        end
        total++; if (got !== 5) begin bad++; $display("FAIL bp_drain_count: got %0d want 5", got); end
    endtask

    task automatic test_redirect();
        int got;
        start(1'b0);
        repeat (4) @(negedge clk);
        // Three entries buffered and one fetch outstanding.
        total++; if (insn_valid !== 1'b1 || imem_en !== 1'b0) begin bad++; $display("FAIL redir_pre: got v=%0b en=%0b want v=1 en=0", insn_valid, imem_en); end
        redirect_valid = 1'b1; redirect_pc = 16'h0040; insn_ready = 1'b1;
        #1;
        total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL redir_no_issue: got %0b want 0", imem_en); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_after: got %0b want 0", insn_valid); end
        total++; if (imem_en !== 1'b1 || imem_addr !== 16'h0040) begin bad++; $display("FAIL redir_restart: got en=%0b addr=%0h want en=1 addr=40", imem_en, imem_addr); end
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (insn_valid) begin
                total++; if (insn_pc_o !== 16'h0040 + 16'(got) || insn_o !== 32'h1040 + 32'(got)) begin bad++; $display("FAIL redir_stream: got pc=%0h insn=%0h want pc=%0h", insn_pc_o, insn_o, 16'h0040 + 16'(got)); end
                got++;
            end
            @(negedge clk);
        end
        total++; if (got !== 3) begin bad++; $display("FAIL redir_count: got %0d want 3", got); end
        // Back-to-back redirects: the later target wins.
        redirect_valid = 1'b1; redirect_pc = 16'h0080;
        @(negedge clk);
        redirect_pc = 16'h0090;
        #1;
        total++; if (imem_en !== 1'b0 || insn_valid !== 1'b0) begin bad++; $display("FAIL b2b_mid: got en=%0b v=%0b want 0 0", imem_en, insn_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_addr !== 16'h0090) begin bad++; $display("FAIL b2b_addr: got %0h want 90", imem_addr); end
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (insn_valid) begin
                total++; if (insn_pc_o !== 16'h0090 + 16'(got)) begin bad++; $display("FAIL b2b_stream: got pc=%0h want %0h", insn_pc_o, 16'h0090 + 16'(got)); end
                got++;
            end
            @(negedge clk);
        end
        total++; if (got !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", got); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [4];
        int got;
        exp_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        got = 0;
        start(1'b1);
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (insn_valid_w) begin
                total++; if (insn_pc_o_w !== exp_pc[got] || insn_o_w !== 32'h1000 + {16'h0, exp_pc[got]}) begin bad++; $display("FAIL wrap_pc: got pc=%0h insn=%0h want pc=%0h", insn_pc_o_w, insn_o_w, exp_pc[got]); end
                got++;
            end
            @(negedge clk);
        end
        total++; if (got !== 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", got); end
    endtask

    task automatic test_random();
        logic [15:0] exp_next;
        int          outstanding;
        exp_next    = 16'h0;
        outstanding = 0;
        start(1'b0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            insn_ready     = 1'($urandom_range(0, 1));
            redirect_valid = (cyc % 20 == 19);
            redirect_pc    = 16'($urandom_range(0, 16'hFFFF));
            #1;
            if (redirect_valid) begin
                total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL rnd_redir_en: cyc=%0d got %0b want 0", cyc, imem_en); end
                exp_next    = redirect_pc;
                outstanding = 0;
            end else begin
                total++; if (imem_en !== (outstanding < 4)) begin bad++; $display("FAIL rnd_issue: cyc=%0d got %0b want %0b", cyc, imem_en, outstanding < 4); end
                if (insn_valid && insn_ready) begin
                    total++;
                    if (insn_pc_o !== exp_next || insn_o !== 32'h1000 + {16'h0, exp_next}) begin
                        bad++;
                        $display("FAIL rnd_stream: cyc=%0d got pc=%0h insn=%0h want pc=%0h", cyc, insn_pc_o, insn_o, exp_next);
                    end
                    exp_next    = exp_next + 16'h1;
                    outstanding = outstanding - 1;
                end
                if (imem_en) outstanding = outstanding + 1;
                total++; if (outstanding > 4) begin bad++; $display("FAIL rnd_occupancy: cyc=%0d got %0d want <=4", cyc, outstanding); end
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int got;
        start(1'b0);
        repeat (6) @(negedge clk);
        total++; if (insn_valid !== 1'b1 || imem_en !== 1'b0) begin bad++; $display("FAIL rmid_full: got v=%0b en=%0b want v=1 en=0", insn_valid, imem_en); end
        rst = 1'b0;
        #1;
        total++; if (imem_en !== 1'b0 || insn_valid !== 1'b0) begin bad++; $display("FAIL rmid_during: got en=%0b v=%0b want 0 0", imem_en, insn_valid); end
        total++; if (insn_o !== 32'h0 || insn_pc_o !== 16'h0) begin bad++; $display("FAIL rmid_outputs: got insn=%0h pc=%0h want 0 0", insn_o, insn_pc_o); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL rmid_after_valid: got %0b want 0", insn_valid); end
        total++; if (imem_en !== 1'b1 || imem_addr !== 16'h0) begin bad++; $display("FAIL rmid_restart: got en=%0b addr=%0h want en=1 addr=0", imem_en, imem_addr); end
        insn_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (insn_valid) begin
                total++; if (insn_pc_o !== 16'(got)) begin bad++; $display("FAIL rmid_stream: got pc=%0h want %0h", insn_pc_o, got); end
                got++;
            end
            @(negedge clk);
        end
        total++; if (got !== 2) begin bad++; $display("FAIL rmid_count: got %0d want 2", got); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
